image_sequencer: RTL and testbench

Controls which image the display shows. It takes next/previous button pulses and an optional frame-counted auto-advance, and holds one pending target index. It commits that index only at a frame boundary, then runs a load handshake with the framebuffer loader. It sits between the debounced button pulses and the image ROM/framebuffer loader, and blanks the display while a load is in progress.

---
 rtl/image_seq_pkg.sv | 22 ++
 rtl/auto_advance_timer.sv | 37 +++
 rtl/image_sequencer.sv | 105 ++++++++++
 tb/tb_image_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/image_seq_pkg.sv
// Shared types, widths and index-wrap helpers for the image sequencer.
package image_seq_pkg;

    typedef enum logic [1:0] {StInit, StIdle, StPend, StLoad} state_e;

    localparam int unsigned SEL_W               = 4;
    localparam int unsigned DEFAULT_NUM_IMAGES  = 4;
    localparam int unsigned DEFAULT_AUTO_FRAMES = 180;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v,
                                                  input int unsigned     n);
        if (int'(v) >= int'(n) - 1) return '0;
        return v + SEL_W'(1);
    endfunction

    function automatic logic [SEL_W-1:0] wrap_dec(input logic [SEL_W-1:0] v,
                                                  input int unsigned     n);
        if (v == '0) return SEL_W'(n - 1);
        return v - SEL_W'(1);
    endfunction

endpackage

// File: rtl/auto_advance_timer.sv
// Counts frame_start pulses while enabled and flags an auto-advance request
// on the frame that completes each AUTO_FRAMES period.
module auto_advance_timer #(
    parameter int unsigned AUTO_FRAMES = 180
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    input  logic enable,
    input  logic clear,
    output logic auto_req
);

    logic [7:0] count_q, count_d;
    logic       at_limit;

    assign at_limit = (count_q == 8'(AUTO_FRAMES - 1));
    assign auto_req = frame_start & enable & at_limit;

    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (frame_start) begin
            count_d = at_limit ? 8'd0 : count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/image_sequencer.sv
// Selects the displayed image: resolves button/auto requests into a pending
// target and commits it at frame boundaries through a loader handshake.
module image_sequencer
    import image_seq_pkg::*;
#(
    parameter int unsigned NUM_IMAGES  = DEFAULT_NUM_IMAGES,
    parameter int unsigned AUTO_FRAMES = DEFAULT_AUTO_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             auto_en,
    input  logic             frame_start,
    input  logic             load_done,
    output logic [SEL_W-1:0] image_select,
    output logic             load_req,
    output logic             blank,
    output logic             busy
);

    state_e           state_q;
    logic [SEL_W-1:0] target_q, target_d;
    logic             manual, auto_req, timer_en;

    assign manual   = btn_next | btn_prev;
    assign timer_en = (state_q == StIdle) & auto_en;

    auto_advance_timer #(
        .AUTO_FRAMES (AUTO_FRAMES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .enable      (timer_en),
        .clear       (manual),
        .auto_req    (auto_req)
    );

    // Simultaneous next+prev cancel; auto yields to any manual pulse.
    always_comb begin
        target_d = target_q;
        if (state_q != StInit) begin
            if ((btn_next && !btn_prev) || (auto_req && !manual)) begin
                target_d = wrap_inc(target_q, NUM_IMAGES);
            end else if (btn_prev && !btn_next) begin
                target_d = wrap_dec(target_q, NUM_IMAGES);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StInit;
            target_q     <= '0;
            image_select <= '0;
            load_req     <= 1'b0;
            blank        <= 1'b1;
            busy         <= 1'b1;
        end else begin
            target_q <= target_d;
            unique case (state_q)
                StInit: begin
                    if (frame_start) begin
                        state_q      <= StLoad;
                        image_select <= '0;
                        load_req     <= 1'b1;
                    end
                end
                StIdle: begin
                    if (target_d != image_select) begin
                        state_q <= StPend;
                        busy    <= 1'b1;
                    end
                end
                StPend: begin
                    // Cancel check uses the registered target, so a request
                    // that lands with frame_start only affects the next load.
                    if (target_q == image_select) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (frame_start) begin
                        state_q      <= StLoad;
                        image_select <= target_q;
                        load_req     <= 1'b1;
                        blank        <= 1'b1;
                    end
                end
                StLoad: begin
                    if (load_done) begin
                        load_req <= 1'b0;
                        blank    <= 1'b0;
                        if (target_d != image_select) begin
                            state_q <= StPend;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_sequencer.sv
// Randomized bench for image_sequencer against a behavioural display model.
module tb_image_sequencer;

    localparam int NI = 4;
    localparam int AF = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       auto_en = 1'b0;
    logic       frame_start = 1'b0;
    logic       load_done = 1'b0;
    logic [3:0] image_select;
    logic       load_req;
    logic       blank;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Model: has the first image been loaded, is a load in flight, is a change waiting.
    bit m_ready, m_loading, m_waiting, m_req;
    int m_sel, m_tgt, m_cnt;

    image_sequencer #(
        .NUM_IMAGES  (NI),
        .AUTO_FRAMES (AF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_next     (btn_next),
        .btn_prev     (btn_prev),
        .auto_en      (auto_en),
        .frame_start  (frame_start),
        .load_done    (load_done),
        .image_select (image_select),
        .load_req     (load_req),
        .blank        (blank),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready   = 1'b0;
        m_loading = 1'b0;
        m_waiting = 1'b0;
        m_req     = 1'b0;
        m_sel     = 0;
        m_tgt     = 0;
        m_cnt     = 0;
    endtask

    task automatic check_outputs(input string phase);
        bit idle;
        idle = m_ready && !m_loading && !m_waiting;
        check({phase, ".image_select"}, int'(image_select), m_sel);
        check({phase, ".load_req"}, int'(load_req), int'(m_req));
        check({phase, ".blank"}, int'(blank), int'(!m_ready || m_loading));
        check({phase, ".busy"}, int'(busy), int'(!idle));
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit idle, manual, fire;
        int tgt_n, cnt_n;
        idle   = m_ready && !m_loading && !m_waiting;
        manual = btn_next || btn_prev;
        fire   = idle && auto_en && frame_start && (m_cnt == AF - 1) && !manual;

        if (!idle || !auto_en || manual) cnt_n = 0;
        else if (frame_start)            cnt_n = (m_cnt + 1) % AF;
        else                             cnt_n = m_cnt;

        tgt_n = m_tgt;
        if (m_ready) begin
            if ((btn_next && !btn_prev) || fire) tgt_n = (m_tgt + 1) % NI;
            else if (btn_prev && !btn_next)      tgt_n = (m_tgt + NI - 1) % NI;
        end

        if (!m_ready) begin
            if (frame_start) begin
                m_ready   = 1'b1;
                m_loading = 1'b1;
                m_sel     = 0;
                m_req     = 1'b1;
            end
        end else if (m_loading) begin
            if (load_done) begin
                m_loading = 1'b0;
                m_req     = 1'b0;
                m_waiting = (tgt_n != m_sel);
            end
        end else if (m_waiting) begin
            if (m_tgt == m_sel) begin
                m_waiting = 1'b0;
            end else if (frame_start) begin
                m_waiting = 1'b0;
                m_loading = 1'b1;
                m_sel     = m_tgt;
                m_req     = 1'b1;
            end
        end else if (tgt_n != m_sel) begin
            m_waiting = 1'b1;
        end

        m_tgt = tgt_n;
        m_cnt = cnt_n;
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #2 check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            btn_next    = ($urandom_range(0, 9) == 0);
            btn_prev    = ($urandom_range(0, 9) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            load_done   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
            model_step();
            @(posedge clk);
            @(negedge clk);
            check_outputs("run");

            // Occasional asynchronous reset, biased toward an in-flight load.
            if ((m_loading && $urandom_range(0, 79) == 0) || $urandom_range(0, 999) == 0) begin
                btn_next    = 1'b0;
                btn_prev    = 1'b0;
                frame_start = 1'b0;
                load_done   = 1'b0;
                reset       = 1'b1;
                #1;
                model_reset();
                check_outputs("async_reset");
                #2 reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
